double_frame_buffer: RTL and testbench



---
 rtl/fb_pkg.sv | 32 +++
 rtl/fb_swap_ctrl.sv | 93 +++++++++
 rtl/xilinx_single_port_ram_read_first.sv | 46 ++++
 rtl/double_frame_buffer.sv | 149 ++++++++++++++
 tb/tb_double_frame_buffer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types for the ping-pong frame buffer: RGB565/RGB888 pixels,
// swap FSM states and the colour expansion helper.
package fb_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } pixel_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        FILL,
        WAIT_VID,
        SWAP,
        CLEAR
    } fb_state_t;

    function automatic rgb888_t rgb565_to_888(input pixel_t p);
        rgb888_t c;
        c.r = {p.r, 3'b000};
        c.g = {p.g, 2'b00};
        c.b = {p.b, 3'b000};
        return c;
    endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Bank swap controller: write gating, swap pulse and front-bank select.
// Optional clear pass after each swap under FB_CLEAR_ON_SWAP_EN.
module fb_swap_ctrl
    import fb_pkg::*;
`ifdef FB_CLEAR_ON_SWAP_EN
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
)
`endif
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic          wr_last,
    input  logic          video_last,
    output logic          wr_ready,
    output logic          swap,
    output logic          front_sel
`ifdef FB_CLEAR_ON_SWAP_EN
   ,output logic          clear_we,
    output logic [AW-1:0] clear_addr
`endif
);

    fb_state_t state;
    logic      last_fire;

    assign last_fire = wr_valid && wr_ready && wr_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            wr_ready   <= 1'b1;
            swap       <= 1'b0;
            front_sel  <= 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
            clear_we   <= 1'b0;
            clear_addr <= '0;
`endif
        end else begin
            swap <= 1'b0;
            case (state)
                FILL: begin
                    if (last_fire) begin
                        wr_ready <= 1'b0;
                        if (video_last) begin
                            state     <= SWAP;
                            swap      <= 1'b1;
                            front_sel <= ~front_sel;
                        end else begin
                            state <= WAIT_VID;
                        end
                    end
                end
                WAIT_VID: begin
                    if (video_last) begin
                        state     <= SWAP;
                        swap      <= 1'b1;
                        front_sel <= ~front_sel;
                    end
                end
                SWAP: begin
`ifdef FB_CLEAR_ON_SWAP_EN
                    state      <= CLEAR;
                    clear_we   <= 1'b1;
                    clear_addr <= '0;
`else
                    state    <= FILL;
                    wr_ready <= 1'b1;
`endif
                end
`ifdef FB_CLEAR_ON_SWAP_EN
                CLEAR: begin
                    if (clear_addr == AW'(DEPTH - 1)) begin
                        state      <= FILL;
                        clear_we   <= 1'b0;
                        clear_addr <= '0;
                        wr_ready   <= 1'b1;
                    end else begin
                        clear_addr <= clear_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= FILL;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM; HIGH_PERFORMANCE adds an output
// register for a 2-cycle read latency.
module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH       = 16,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end
            ram_data <= mem[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_out_reg
            logic [RAM_WIDTH-1:0] douta_reg;
            always_ff @(posedge clka) begin
                if (rsta) begin
                    douta_reg <= '0;
                end else if (regcea) begin
                    douta_reg <= ram_data;
                end
            end
            assign douta = douta_reg;
        end else begin : g_no_out_reg
            assign douta = ram_data;
        end
    endgenerate

endmodule

// File: rtl/double_frame_buffer.sv
// Ping-pong frame buffer: renderer fills the back bank, video scans the
// front bank upscaled. Optional post-swap clear: FB_CLEAR_ON_SWAP_EN.
module double_frame_buffer
    import fb_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 16,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int SCALE_SHIFT   = 2,
`ifdef FB_CLEAR_ON_SWAP_EN
    parameter logic [PIXEL_WIDTH-1:0] CLEAR_COLOR = 16'h0000,
`endif
    localparam int DEPTH  = SCREEN_WIDTH * SCREEN_HEIGHT,
    // one spare bit keeps out-of-range addresses expressible when DEPTH is 2^n
    localparam int ADDR_W = $clog2(DEPTH + 1)
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   video_last_in,
    input  logic                   wr_valid_in,
    input  logic [ADDR_W-1:0]      wr_addr_in,
    input  logic [PIXEL_WIDTH-1:0] wr_data_in,
    input  logic                   wr_last_in,
    output logic                   wr_ready_out,
    output logic [23:0]            rgb_out,
    output logic                   front_sel_out,
    output logic                   swap_out
);

    localparam int RAM_AW = $clog2(DEPTH);

    logic                   wr_we;
    logic                   back_we;
    logic [RAM_AW-1:0]      back_addr;
    logic [PIXEL_WIDTH-1:0] back_data;
    logic [RAM_AW-1:0]      rd_addr;
    logic                   active;
    logic [1:0]             act_q;
    logic [1:0]             sel_q;
    logic [RAM_AW-1:0]      addr_a;
    logic [RAM_AW-1:0]      addr_b;
    logic [PIXEL_WIDTH-1:0] dout_a;
    logic [PIXEL_WIDTH-1:0] dout_b;

    assign wr_we = wr_valid_in && wr_ready_out
                && (int'(wr_addr_in) < DEPTH);

`ifdef FB_CLEAR_ON_SWAP_EN
    logic              clear_we;
    logic [RAM_AW-1:0] clear_addr;

    fb_swap_ctrl #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ctrl (
        .clk        (pixel_clk_in),
        .rst_n      (rst_n_in),
        .wr_valid   (wr_valid_in),
        .wr_last    (wr_last_in),
        .video_last (video_last_in),
        .wr_ready   (wr_ready_out),
        .swap       (swap_out),
        .front_sel  (front_sel_out),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign back_we   = clear_we || wr_we;
    assign back_addr = clear_we ? clear_addr : RAM_AW'(wr_addr_in);
    assign back_data = clear_we ? CLEAR_COLOR : wr_data_in;
`else
    fb_swap_ctrl u_ctrl (
        .clk        (pixel_clk_in),
        .rst_n      (rst_n_in),
        .wr_valid   (wr_valid_in),
        .wr_last    (wr_last_in),
        .video_last (video_last_in),
        .wr_ready   (wr_ready_out),
        .swap       (swap_out),
        .front_sel  (front_sel_out)
    );

    assign back_we   = wr_we;
    assign back_addr = RAM_AW'(wr_addr_in);
    assign back_data = wr_data_in;
`endif

    assign rd_addr = RAM_AW'(hcount_in >> SCALE_SHIFT)
                   + RAM_AW'(SCREEN_WIDTH)
                   * RAM_AW'(vcount_in >> SCALE_SHIFT);

    assign active = (int'(hcount_in) < (SCREEN_WIDTH << SCALE_SHIFT))
                 && (int'(vcount_in) < (SCREEN_HEIGHT << SCALE_SHIFT));

    // bank A is front while front_sel_out is 0
    assign addr_a = front_sel_out ? back_addr : rd_addr;
    assign addr_b = front_sel_out ? rd_addr : back_addr;

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (PIXEL_WIDTH),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_bank_a (
        .addra  (addr_a),
        .dina   (back_data),
        .clka   (pixel_clk_in),
        .wea    (front_sel_out && back_we),
        .ena    (1'b1),
        .rsta   (!rst_n_in),
        .regcea (1'b1),
        .douta  (dout_a)
    );

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (PIXEL_WIDTH),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_bank_b (
        .addra  (addr_b),
        .dina   (back_data),
        .clka   (pixel_clk_in),
        .wea    (!front_sel_out && back_we),
        .ena    (1'b1),
        .rsta   (!rst_n_in),
        .regcea (1'b1),
        .douta  (dout_b)
    );

    // select pipe keeps in-flight reads on the bank they were issued to
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            act_q <= '0;
            sel_q <= '0;
        end else begin
            act_q <= {act_q[0], active};
            sel_q <= {sel_q[0], front_sel_out};
        end
    end

    always_comb begin
        rgb_out = '0;
        if (act_q[1]) begin
            rgb_out = rgb565_to_888(pixel_t'(sel_q[1] ? dout_b : dout_a));
        end
    end

endmodule

// File: tb/tb_double_frame_buffer.sv
// Scoreboard bench for double_frame_buffer (8x4 screen, 2x upscale);
// clear-pass scenarios run when FB_CLEAR_ON_SWAP_EN is defined.
module tb_double_frame_buffer;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int S     = 1;
    localparam int N     = W * H;
    localparam int AW    = $clog2(N + 1);
    localparam logic [15:0] CLR_C = 16'h001F;
`ifdef FB_CLEAR_ON_SWAP_EN
    localparam int CLR_CYC = N;
`else
    localparam int CLR_CYC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   hcount = 11'd1000;
    logic [9:0]    vcount = 10'd1000;
    logic          video_last = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          wr_last = 1'b0;
    logic          wr_ready;
    logic [23:0]   rgb;
    logic          front_sel;
    logic          swap;

    int n_tests = 0;
    int n_fail  = 0;
    int swap_cnt = 0;

    logic [15:0] bank_m [0:1][0:N-1];
    logic        front_m = 1'b0;
    logic [23:0] exp_q [$];

    always #5 clk = ~clk;

    always @(negedge clk) if (swap) swap_cnt++;

    double_frame_buffer #(
        .PIXEL_WIDTH   (16),
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
`ifdef FB_CLEAR_ON_SWAP_EN
        .CLEAR_COLOR   (CLR_C),
`endif
        .SCALE_SHIFT   (S)
    ) dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .video_last_in (video_last),
        .wr_valid_in   (wr_valid),
        .wr_addr_in    (wr_addr),
        .wr_data_in    (wr_data),
        .wr_last_in    (wr_last),
        .wr_ready_out  (wr_ready),
        .rgb_out       (rgb),
        .front_sel_out (front_sel),
        .swap_out      (swap)
    );

    function automatic logic [23:0] exp_px(input int h, input int v);
        logic [15:0] p;
        if (h < (W << S) && v < (H << S)) begin
            p = bank_m[front_m][(h >> S) + W * (v >> S)];
            return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
        end
        return 24'h0;
    endfunction

    function automatic logic [15:0] pat(input int a, input int seed);
        return 16'((a * 2311 + seed * 977 + 7) & 16'hFFFF);
    endfunction

    // caller is aligned 1 time unit after a rising edge; so is the return
    task automatic write_px(input int a, input logic [15:0] d,
                            input bit last, input bit vl);
        bit ok = 0;
        int t  = 0;
        wr_valid   = 1'b1;
        wr_addr    = AW'(a);
        wr_data    = d;
        wr_last    = last;
        video_last = vl;
        while (!ok && t < 100) begin
            @(negedge clk);
            if (wr_ready) ok = 1;
            @(posedge clk); #1;
            t++;
        end
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        video_last = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_accept addr=%0d: ready never seen, required ready", a);
        end else if (a < N) begin
            bank_m[!front_m][a] = d;
        end
    endtask

    task automatic check_swap(input string nm, input int cnt0);
        int low = 0;
        @(negedge clk);
        n_tests++;
        if (swap !== 1'b1 || front_sel !== !front_m) begin
            n_fail++;
            $display("FAIL %s_swap: swap=%b front=%b, required swap=1 front=%b",
                     nm, swap, front_sel, !front_m);
        end
        front_m = !front_m;
`ifdef FB_CLEAR_ON_SWAP_EN
        for (int i = 0; i < N; i++) bank_m[!front_m][i] = CLR_C;
`endif
        @(posedge clk); #1;
        while (low < 200) begin
            @(negedge clk);
            if (wr_ready) break;
            low++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        n_tests++;
        if (low !== CLR_CYC) begin
            n_fail++;
            $display("FAIL %s_ready_low: %0d cycles, required %0d", nm, low, CLR_CYC);
        end
        n_tests++;
        if (swap_cnt - cnt0 !== 1) begin
            n_fail++;
            $display("FAIL %s_swap_count: %0d pulses, required 1", nm, swap_cnt - cnt0);
        end
    endtask

    task automatic swap_via_video(input string nm);
        int c0 = swap_cnt;
        video_last = 1'b1;
        @(posedge clk); #1;
        video_last = 1'b0;
        check_swap(nm, c0);
    endtask

    task automatic scan(input string nm);
        int pts_h [$];
        int pts_v [$];
        logic [23:0] e;
        for (int v = 0; v < (H << S) + 2; v++)
            for (int h = 0; h < (W << S) + 2; h++) begin
                pts_h.push_back(h);
                pts_v.push_back(v);
            end
        pts_h.push_back(100);
        pts_v.push_back(50);
        for (int i = 0; i < pts_h.size() + 2; i++) begin
            if (i < pts_h.size()) begin
                hcount = 11'(pts_h[i]);
                vcount = 10'(pts_v[i]);
                exp_q.push_back(exp_px(pts_h[i], pts_v[i]));
            end else begin
                hcount = 11'd1000;
                vcount = 10'd1000;
            end
            @(negedge clk);
            if (i >= 2) begin
                e = exp_q.pop_front();
                n_tests++;
                if (rgb !== e) begin
                    n_fail++;
                    $display("FAIL %s_rgb h=%0d v=%0d: got %h, required %h",
                             nm, pts_h[i-2], pts_v[i-2], rgb, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rgb !== 24'h0 || front_sel !== 1'b0 ||
            wr_ready !== 1'b1 || swap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rgb=%h front=%b ready=%b swap=%b, required 0/0/1/0",
                     rgb, front_sel, wr_ready, swap);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill_swap;
        for (int a = 0; a < N; a++)
            write_px(a, 16'hF800, a == N - 1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (wr_ready !== 1'b0 || swap !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_wait: ready=%b swap=%b, required 0/0", wr_ready, swap);
        end
        @(posedge clk); #1;
        swap_via_video("fill");
        scan("fill");
    endtask

    task automatic test_simultaneous;
        int c0;
        for (int a = 0; a < N - 1; a++)
            write_px(a, pat(a, 1), 1'b0, 1'b0);
        c0 = swap_cnt;
        write_px(N - 1, pat(N - 1, 1), 1'b1, 1'b1);
        check_swap("simul", c0);
        scan("simul");
    endtask

    task automatic test_no_video;
        int c0;
        for (int a = 0; a < N; a++)
            write_px(a, pat(a, 2), a == N - 1, 1'b0);
        c0 = swap_cnt;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (swap_cnt !== c0 || wr_ready !== 1'b0 || front_sel !== front_m) begin
            n_fail++;
            $display("FAIL no_video: swaps=%0d ready=%b front=%b, required %0d/0/%b",
                     swap_cnt - c0, wr_ready, front_sel, 0, front_m);
        end
        @(posedge clk); #1;
        scan("hold_old");
        swap_via_video("late_video");
        scan("late_video");
    endtask

    task automatic test_repeat_bad_addr;
        int c0 = swap_cnt;
        video_last = 1'b1;
        @(posedge clk); #1;
        video_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (front_sel !== front_m || swap_cnt !== c0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_frame: front=%b swaps=%0d ready=%b, required %b/0/1",
                     front_sel, swap_cnt - c0, wr_ready, front_m);
        end
        @(posedge clk); #1;
        write_px(N, 16'hBEEF, 1'b0, 1'b0);
        write_px(40, 16'h1234, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_addr_last: ready=%b, required 0", wr_ready);
        end
        @(posedge clk); #1;
        swap_via_video("bad_addr");
        scan("bad_addr");
    endtask

`ifdef FB_CLEAR_ON_SWAP_EN
    task automatic test_clear;
        for (int a = 0; a < N; a++)
            write_px(a, pat(a, 3), a == N - 1, 1'b0);
        swap_via_video("clear_a");
        scan("clear_a");
        write_px(40, 16'h0000, 1'b1, 1'b0);
        swap_via_video("clear_b");
        scan("clear_b");
    endtask

    task automatic test_reset_mid_clear;
        write_px(40, 16'h0000, 1'b1, 1'b0);
        video_last = 1'b1;
        @(posedge clk); #1;
        video_last = 1'b0;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (wr_ready !== 1'b1 || front_sel !== 1'b0 || swap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: ready=%b front=%b swap=%b, required 1/0/0",
                     wr_ready, front_sel, swap);
        end
        front_m = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_midop;
        for (int a = 0; a < 5; a++)
            write_px(a, pat(a, 4), a == 4, 1'b0);
        @(negedge clk);
        n_tests++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_wait: ready=%b, required 0", wr_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (wr_ready !== 1'b1 || front_sel !== 1'b0 || swap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: ready=%b front=%b swap=%b, required 1/0/0",
                     wr_ready, front_sel, swap);
        end
        front_m = 1'b0;
        @(posedge clk); #1;
        scan("ram_kept");
    endtask

    initial begin
        test_reset;
        test_fill_swap;
        test_simultaneous;
        test_no_video;
        test_repeat_bad_addr;
`ifdef FB_CLEAR_ON_SWAP_EN
        test_clear;
        test_reset_mid_clear;
`endif
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
